cla_nibble_seq: RTL and testbench

CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

---
 rtl/cla_nibble_seq_if.sv | 30 +++
 rtl/cla_nibble_seq.sv | 104 ++++++++++
 tb/tb_cla_nibble_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cla_nibble_seq_if.sv
// rtl/cla_nibble_seq_if.sv - operand/result handshake and external 4-bit CLA slice bus
interface cla_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_cin;
  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport slave (
    input  in_valid, a, b, cin, sub, cla_sum, cla_cout, out_ready,
    output in_ready, cla_a, cla_b, cla_cin, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, sub, cla_sum, cla_cout, out_ready,
    input  in_ready, cla_a, cla_b, cla_cin, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - word adder sequenced one nibble per cycle through an external CLA slice
// Optional subtract on accept enabled by macro CLA_SEQ_SUB_EN.
module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  cla_nibble_seq_if.slave     bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = $clog2(NIB);
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_acc;
  logic             c_acc;
  logic             run;

  // Operand conditioning at accept; subtract is a-b as a + ~b + 1.
  always_comb begin
    b_acc = bus.b;
    c_acc = bus.cin;
`ifdef CLA_SEQ_SUB_EN
    if (bus.sub) begin
      b_acc = ~bus.b;
      c_acc = 1'b1;
    end
`endif
  end

  assign run           = (state_q == RUN);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.cla_a     = run ? a_q[{k_q, 2'b00} +: 4] : 4'h0;
  assign bus.cla_b     = run ? b_q[{k_q, 2'b00} +: 4] : 4'h0;
  assign bus.cla_cin   = run ? carry_q : 1'b0;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_acc;
          carry_d = c_acc;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{k_q, 2'b00} +: 4] = bus.cla_sum;
        carry_d = bus.cla_cout;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          cout_d  = bus.cla_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb/tb_cla_nibble_seq.sv - self-checking bench for cla_nibble_seq with arithmetic reference model
module tb_cla_nibble_seq;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The external slice is a plain 4-bit adder.
  assign {bus.cla_cout, bus.cla_sum} = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {4'b0, bus.cla_cin};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.a   = WIDTH'($urandom);
    bus.b   = WIDTH'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [WIDTH-1:0] bx;
    logic [63:0]      be;
    logic [63:0]      c0;
    logic [63:0]      tot;
    logic [63:0]      mask;
    logic [63:0]      part;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    bx = b;
    c0 = {63'b0, cin};
`ifdef CLA_SEQ_SUB_EN
    if (sub) begin
      bx = ~b;
      c0 = 64'd1;
    end
`endif
    be       = {{(64-WIDTH){1'b0}}, bx};
    tot      = {{(64-WIDTH){1'b0}}, a} + be + c0;
    exp_sum  = tot[WIDTH-1:0];
    exp_cout = tot[WIDTH];

    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    for (int k = 0; k < NIB; k++) begin
      mask = (64'd1 << (4 * k)) - 64'd1;
      part = ({{(64-WIDTH){1'b0}}, a} & mask) + (be & mask) + c0;
      chk("run_out_valid", bus.out_valid, 0);
      chk("run_in_ready", bus.in_ready, 0);
      chk("run_cla_a", bus.cla_a, (a >> (4 * k)) & 4'hF);
      chk("run_cla_b", bus.cla_b, (bx >> (4 * k)) & 4'hF);
      chk("run_cla_cin", bus.cla_cin, (part >> (4 * k)) & 64'd1);
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
    end
    chk("done_out_valid", bus.out_valid, 1);
    chk("done_sum", bus.sum, exp_sum);
    chk("done_cout", bus.cout, exp_cout);
    chk("done_cla_idle", {bus.cla_a, bus.cla_b, bus.cla_cin}, 0);
    bus.in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_sum", {bus.cout, bus.sum}, {exp_cout, exp_sum});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    chk("idle_sum_kept", {bus.cout, bus.sum}, {exp_cout, exp_sum});
    @(posedge clk);
    @(negedge clk);
    chk("no_accept_in_done", bus.in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", {bus.cout, bus.sum}, 0);
    chk("rst_cla_idle", {bus.cla_a, bus.cla_b, bus.cla_cin}, 0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op(16'hBEEF, 16'h1357, 1'b1, 1'b0, 10);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Abandon an operation with reset in its second RUN cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b0; bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_sum", {bus.cout, bus.sum}, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_valid", bus.out_valid, 0);
    end
    run_op(16'h00F0, 16'h0F10, 1'b1, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
